rvfi_retire_sequencer: RTL
==========================

RVFI_RETIRE_SEQUENCER -- requirements
Module: rvfi_retire_sequencer

Interface
REQ-001 SHALL have parameter NRET, default 2: number of retirement channels per cycle.
REQ-002 SHALL have parameter XLEN, default 32: data/address width.
REQ-003 SHALL have parameter DEPTH, default 8: buffer entries; power of two, at least NRET.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_valid  input  NRET  per-channel retirement valid.
REQ-007 SHALL have port in_order  input  NRET*64  per-channel instruction order.
REQ-008 SHALL have port in_mem_addr  input  NRET*XLEN  per-channel memory address.
REQ-009 SHALL have port in_mem_rmask and in_mem_wmask  input  NRET*XLEN/8 each  per-channel byte masks.
REQ-010 SHALL have port in_mem_rdata and in_mem_wdata  input  NRET*XLEN each  per-channel data.
REQ-011 SHALL have port in_ready  output  1  high when free entries >= NRET.
REQ-012 SHALL have ports out_valid  output  1, and out_ready  input  1: single-channel handshake toward a downstream memory checker.
REQ-013 SHALL have ports out_order, out_mem_addr, out_mem_rmask, out_mem_wmask, out_mem_rdata, out_mem_wdata  output  single-channel widths  head entry.
REQ-014 SHALL have port overflow  output  1  sticky: a retirement was dropped.
REQ-015 SHALL have port order_err  output  1  sticky order-sequence error.

Function
REQ-016 SHALL push, each cycle, every channel with in_valid set, in ascending channel index, into a circular buffer.
REQ-017 SHALL accept the push only when free entries >= popcount(in_valid), with free counted before this cycle's pop; otherwise SHALL drop all channels of that cycle and set overflow.
REQ-018 SHALL assert out_valid whenever occupancy > 0 and SHALL present the oldest entry on the out_* ports.
REQ-019 SHALL pop one entry on a cycle with out_valid && out_ready.
REQ-020 SHALL NOT bypass: an entry pushed in cycle N becomes visible on out_* no earlier than cycle N+1.
REQ-021 SHALL update occupancy as occupancy + pushes - pop when push and pop occur in the same cycle, including at full and at empty.
REQ-022 SHALL wrap read and write pointers modulo DEPTH.
REQ-023 SHALL hold out_* stable while out_valid && !out_ready.
REQ-024 SHALL treat in_valid = 0 as a no-op and leave occupancy unchanged except for pop.
REQ-025 SHALL keep occupancy in log2(DEPTH)+1 bits and never let it exceed DEPTH.

Reset
REQ-026 SHALL, when resetn is low, asynchronously clear pointers, occupancy, overflow, order_err and the expected-order register.
REQ-027 SHALL reset outputs to out_valid=0, in_ready=1, overflow=0, order_err=0.
REQ-028 SHALL NOT reset buffer storage; out_* data are don't-care while out_valid=0.
REQ-029 SHALL discard all buffered entries on reset asserted mid-operation, with no pop completing in that cycle.

Configuration
REQ-030 SHALL use macro RVFI_SEQ_ORDER_CHECK_EN to enable order checking.
REQ-031 SHALL, with RVFI_SEQ_ORDER_CHECK_EN defined, record the first popped out_order after reset and set order_err if any later popped out_order is not the previous value + 1 (64-bit wrap).
REQ-032 SHALL, with RVFI_SEQ_ORDER_CHECK_EN undefined, tie order_err to 0 and include no order-tracking logic.

Verification
REQ-033 SHALL cover: NRET=2, in_valid=2'b11 with orders 5,6 and out_ready=1 -> out_order 5 in cycle N+1, then 6 in N+2, out_valid=0 in N+3.
REQ-034 SHALL cover: DEPTH=8 filled to 7 entries, in_valid=2'b11, out_ready=0 -> both dropped, overflow=1 and stays set, occupancy=7.
REQ-035 SHALL cover: occupancy=7, in_valid=2'b01 with pop in the same cycle -> accepted, occupancy stays 7.
REQ-036 SHALL cover: 20 single-channel pushes with continuous pops -> pointers wrap and out_order is in strict push order.
REQ-037 SHALL cover: macro defined, popped orders 10,11,13 -> order_err=1 after the pop of 13; macro undefined -> order_err stays 0.
REQ-038 SHALL cover: resetn pulsed low mid-stream with 4 entries buffered -> out_valid=0 and in_ready=1 immediately, overflow=0.

Source files
------------

// File: rtl/rvfi_retire_sequencer.sv
// Collects up to NRET RVFI memory retirements per cycle into a circular buffer and
// replays them one per handshake, in retirement order. Define RVFI_SEQ_ORDER_CHECK_EN to add order tracking.
module rvfi_retire_sequencer #(
  parameter int NRET  = 2,
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [NRET-1:0]          in_valid,
  input  logic [NRET*64-1:0]       in_order,
  input  logic [NRET*XLEN-1:0]     in_mem_addr,
  input  logic [NRET*XLEN/8-1:0]   in_mem_rmask,
  input  logic [NRET*XLEN/8-1:0]   in_mem_wmask,
  input  logic [NRET*XLEN-1:0]     in_mem_rdata,
  input  logic [NRET*XLEN-1:0]     in_mem_wdata,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [63:0]              out_order,
  output logic [XLEN-1:0]          out_mem_addr,
  output logic [XLEN/8-1:0]        out_mem_rmask,
  output logic [XLEN/8-1:0]        out_mem_wmask,
  output logic [XLEN-1:0]          out_mem_rdata,
  output logic [XLEN-1:0]          out_mem_wdata,
  output logic                     overflow,
  output logic                     order_err
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int MASK_W = XLEN / 8;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] NRET_C  = CNT_W'(NRET);

  typedef struct packed {
    logic [63:0]       order;
    logic [XLEN-1:0]   addr;
    logic [MASK_W-1:0] rmask;
    logic [MASK_W-1:0] wmask;
    logic [XLEN-1:0]   rdata;
    logic [XLEN-1:0]   wdata;
  } entry_t;

  entry_t mem [DEPTH];
  entry_t in_entry [NRET];
  logic [PTR_W-1:0] slot [NRET];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] free_cnt, n_push;
  logic             overflow_q, overflow_d;
  logic             accept, pop;

  always_comb begin
    for (int i = 0; i < NRET; i++) begin
      in_entry[i].order = in_order[i*64 +: 64];
      in_entry[i].addr  = in_mem_addr[i*XLEN +: XLEN];
      in_entry[i].rmask = in_mem_rmask[i*MASK_W +: MASK_W];
      in_entry[i].wmask = in_mem_wmask[i*MASK_W +: MASK_W];
      in_entry[i].rdata = in_mem_rdata[i*XLEN +: XLEN];
      in_entry[i].wdata = in_mem_wdata[i*XLEN +: XLEN];
    end
  end

  // NOTE: every variable in always_comb gets a value on every path, so no latch is inferred.
  always_comb begin
    n_push = '0;
    // Valid channels are packed into consecutive slots in ascending channel order.
    for (int i = 0; i < NRET; i++) begin
      slot[i] = wr_ptr_q + n_push[PTR_W-1:0];
      if (in_valid[i]) n_push = n_push + CNT_W'(1);
    end
    free_cnt   = DEPTH_C - count_q;
    pop        = out_valid && out_ready;
    accept     = (n_push <= free_cnt);
    wr_ptr_d   = accept ? wr_ptr_q + n_push[PTR_W-1:0] : wr_ptr_q;
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + (accept ? n_push : '0) - CNT_W'(pop);
    overflow_d = overflow_q | ~accept;
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage has no reset; its contents are only observed while out_valid is high.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NRET; i++) begin
      if (accept && in_valid[i]) mem[slot[i]] <= in_entry[i];
    end
  end

  assign in_ready      = (free_cnt >= NRET_C);
  assign out_valid     = (count_q != '0);
  assign overflow      = overflow_q;
  assign out_order     = mem[rd_ptr_q].order;
  assign out_mem_addr  = mem[rd_ptr_q].addr;
  assign out_mem_rmask = mem[rd_ptr_q].rmask;
  assign out_mem_wmask = mem[rd_ptr_q].wmask;
  assign out_mem_rdata = mem[rd_ptr_q].rdata;
  assign out_mem_wdata = mem[rd_ptr_q].wdata;

`ifdef RVFI_SEQ_ORDER_CHECK_EN
  logic        seen_q, seen_d;
  logic        order_err_q, order_err_d;
  logic [63:0] exp_order_q, exp_order_d;

  // The first pop after reset only seeds the expected value.
  always_comb begin
    seen_d      = seen_q;
    order_err_d = order_err_q;
    exp_order_d = exp_order_q;
    if (pop) begin
      seen_d      = 1'b1;
      exp_order_d = out_order + 64'd1;
      if (seen_q && (out_order != exp_order_q)) order_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      seen_q      <= 1'b0;
      order_err_q <= 1'b0;
      exp_order_q <= '0;
    end else begin
      seen_q      <= seen_d;
      order_err_q <= order_err_d;
      exp_order_q <= exp_order_d;
    end
  end

  assign order_err = order_err_q;
`else
  assign order_err = 1'b0;
`endif

endmodule
